// File: rtl/signed_digit_display.sv
// Signed-digit display stage: holds a 4-bit two's-complement value and scans it
// as sign-magnitude onto an active-low, 4-digit, time-multiplexed seven-segment display.
module signed_digit_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       negative
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [3:0]    held_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [6:0]    seg_reg, seg_next;
  logic [3:0]    an_reg, an_next;

  logic       wrap;
  logic       neg;
  logic [3:0] mag;
  logic [6:0] mag_seg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_reg <= 4'd0;
      cnt_reg  <= '0;
      idx_reg  <= 2'd0;
      seg_reg  <= SEG_BLANK;
      an_reg   <= 4'b1111;
    end else begin
      if (load) begin
        held_reg <= value;
      end
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  // Refresh counter and digit index run freely, independent of load.
  assign wrap = (cnt_reg == CNT_MAX);

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    idx_next = idx_reg;
    if (wrap) begin
      cnt_next = '0;
      idx_next = idx_reg + 2'd1;
    end
  end

  // Sign-magnitude: -8 maps to magnitude 8 through the modulo-16 negate.
  assign neg = held_reg[3];
  assign mag = neg ? (~held_reg + 4'd1) : held_reg;

  always_comb begin
    mag_seg = SEG_BLANK;
    case (mag)
      4'd0:    mag_seg = 7'b1000000;
      4'd1:    mag_seg = 7'b1111001;
      4'd2:    mag_seg = 7'b0100100;
      4'd3:    mag_seg = 7'b0110000;
      4'd4:    mag_seg = 7'b0011001;
      4'd5:    mag_seg = 7'b0010010;
      4'd6:    mag_seg = 7'b0000010;
      4'd7:    mag_seg = 7'b1111000;
      4'd8:    mag_seg = 7'b0000000;
      default: mag_seg = SEG_BLANK;
    endcase
  end

  // Exactly one anode low, decoded straight from the index.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign an_next[gi] = (idx_reg != 2'(gi));
    end
  endgenerate

  always_comb begin
    seg_next = SEG_BLANK;
    case (idx_reg)
      2'd0:    seg_next = mag_seg;
      2'd1:    seg_next = neg ? SEG_MINUS : SEG_BLANK;
      default: seg_next = SEG_BLANK;
    endcase
  end

  assign seg      = seg_reg;
  assign an       = an_reg;
  assign dp       = 1'b1;
  assign negative = held_reg[3];

endmodule

// File: doc/signed_digit_display.md
# signed_digit_display

Downstream display stage for the 4-bit two's-complement negator. Captures a 4-bit two's-complement result on a load strobe, converts it to sign-magnitude, and drives a time-multiplexed, active-low, 4-digit seven-segment display:

- digit 0 shows the magnitude (0–8);
- digit 1 shows a minus sign when the value is negative;
- digits 2–3 are blank.

## Interface

**Parameters**
- REFRESH_DIV, 100000: clock cycles each digit stays lit before the scan advances. Legal range is ≥1. Benches use 4.

**Ports**
- clk, input, 1: system clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- value, input, 4: two's-complement operand (negator output).
- load, input, 1: on a rising edge with load=1, `value` is captured into the held register.
- seg, output, 7: segment drive, active-low. seg[0]=a … seg[6]=g.
- an, output, 4: digit anodes, active-low, one-hot-low while scanning.
- dp, output, 1: decimal point, active-low. Constant 1 (off).
- negative, output, 1: registered sign of the held value (held[3]).

## Operation

**Held register**
- 4 bits, reset to 0.
- Loads `value` on any edge with load=1; otherwise retains its contents.
- Repeated loads in consecutive cycles each overwrite the register.

**Sign-magnitude conversion** (combinational from held)
- neg = held[3].
- mag = neg ? (~held + 1) : held, computed modulo 16 as unsigned 4 bits.
- held=4'b1000 (−8) gives mag=8. This is the only case with mag ≥ 8.

**Refresh counter**
- Width ceil(log2(REFRESH_DIV)), minimum 1 bit. Counts 0..REFRESH_DIV−1, then wraps to 0.
- Runs continuously and is not affected by `load`.

**Digit index**
- 2 bits. Increments (mod 4) on each cycle where the counter wraps.

**Digit selection** (registered into seg/an every cycle, from the current index and held)
- Index 0: an=1110, seg=digit(mag).
- Index 1: an=1101, seg = neg ? minus : blank.
- Index 2: an=1011, seg=blank.
- Index 3: an=0111, seg=blank.

**Segment patterns** (g..a, active-low)
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 4 = 0011001
- 5 = 0010010
- 6 = 0000010
- 7 = 1111000
- 8 = 0000000
- minus = 0111111
- blank = 1111111
- mag values 9–15 cannot occur; the default branch decodes them to blank.

## Timing

**Reset values** (asserted asynchronously, immediately)
- seg=1111111, an=1111, dp=1, negative=0
- held=0, counter=0, index=0

**First edges after reset release**
- First rising edge: an=1110, seg=1000000 (the digit "0").

**Load latency**
- load=1 at edge k updates held and negative at edge k.
- seg reflects the new value at edge k+1, provided index selects the affected digit.

**Scan timing**
- Index changes on the edge where counter = REFRESH_DIV−1.
- seg/an follow one edge later, so each digit is lit for exactly REFRESH_DIV cycles.
- With REFRESH_DIV=1, the index advances every cycle.
- Full scan period is 4·REFRESH_DIV cycles.

**Simultaneous events**
- A load on the same edge as an index advance: both take effect. The next edge shows the new value on the new index.

**Reset mid-scan**
- All state returns to reset values; scanning restarts at index 0.

**Glitch-free anodes**
- `an` never has more than one bit low in any cycle.

## Test plan

1. **Reset.** Assert reset mid-scan, with REFRESH_DIV=4 → seg=1111111, an=1111, negative=0 immediately. After release, first edge → an=1110, seg=1000000.
2. **Positive value.** Load value=0011 → negative=1'b0 same edge. Index 0 → seg=0110000. Index 1 → seg=1111111.
3. **Negative value.** Load value=1101 (−3) → negative=1. Index 0 → seg=0110000. Index 1 → seg=0111111.
4. **Most-negative value.** Load value=1000 → mag=8. Index 0 → seg=0000000. Index 1 → minus pattern. Also sweep all 16 values and compare against a sign-magnitude model.
5. **Scan cadence.** REFRESH_DIV=4, observe 32 cycles → an sequence 1110,1101,1011,0111, each held exactly 4 cycles. Never more than one anode low. dp=1 throughout.
6. **Load on wrap edge.** Load value=1111 on the edge where index 0→1 → the next edge shows an=1101, seg=0111111. The following index-0 window shows seg=1111001.
